// File: rtl/cam_param.sv
// Parametrised CAM with per-entry valid bits, invalidate, masked search,
// multi-hit detection, occupancy tracking and a 2-stage pipelined search.
module cam_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              read_enable_i,
  input  logic [IDX_W-1:0]  read_index_i,
  input  logic              write_enable_i,
  input  logic [IDX_W-1:0]  write_index_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic              inval_enable_i,
  input  logic [IDX_W-1:0]  inval_index_i,
  input  logic              search_enable_i,
  input  logic [DATA_W-1:0] search_data_i,
  input  logic [DATA_W-1:0] search_mask_i,
  output logic              read_valid_o,
  output logic [DATA_W-1:0] read_value_o,
  output logic              search_done_o,
  output logic              search_valid_o,
  output logic [IDX_W-1:0]  search_index_o,
  output logic              search_multi_o,
  output logic [IDX_W:0]    occupancy_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  match_now;
  logic [DEPTH-1:0]  s1_match;
  logic              s1_done;
  logic [IDX_W-1:0]  enc_idx;
  logic              enc_any;
  logic              enc_multi;
  logic              occ_inc;
  logic              occ_dec;

  always_comb begin
    match_now = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_now[i] = valid[i] & (((mem[i] ^ search_data_i) & search_mask_i) == '0);
    end
  end

  // Lowest set index wins; two or more set bits flag a multi-hit.
  always_comb begin
    enc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (s1_match[i]) enc_idx = IDX_W'(i);
    end
    enc_any   = |s1_match;
    enc_multi = |(s1_match & (s1_match - DEPTH'(1)));
  end

  // A same-index write overrides the invalidate, so it must not decrement.
  always_comb begin
    occ_inc = write_enable_i & ~valid[write_index_i];
    occ_dec = inval_enable_i & valid[inval_index_i] &
              ~(write_enable_i && (write_index_i == inval_index_i));
  end

  always_ff @(posedge clk_i) begin
    if (write_enable_i) mem[write_index_i] <= write_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid          <= '0;
      occupancy_o    <= '0;
      read_valid_o   <= 1'b0;
      read_value_o   <= '0;
      s1_done        <= 1'b0;
      s1_match       <= '0;
      search_done_o  <= 1'b0;
      search_valid_o <= 1'b0;
      search_index_o <= '0;
      search_multi_o <= 1'b0;
    end else begin
      if (inval_enable_i) valid[inval_index_i] <= 1'b0;
      if (write_enable_i) valid[write_index_i] <= 1'b1;
      occupancy_o <= occupancy_o + (IDX_W+1)'(occ_inc) - (IDX_W+1)'(occ_dec);

      read_valid_o <= read_enable_i & valid[read_index_i];
      read_value_o <= (read_enable_i && valid[read_index_i]) ? mem[read_index_i] : '0;

      s1_done        <= search_enable_i;
      s1_match       <= search_enable_i ? match_now : '0;
      search_done_o  <= s1_done;
      search_valid_o <= s1_done & enc_any;
      search_index_o <= s1_done ? enc_idx : '0;
      search_multi_o <= s1_done & enc_multi;
    end
  end

endmodule

// File: tb/tb_cam_param.sv
// Directed self-checking bench for cam_param; each task covers one scenario
// with hand-computed expectations.
module tb_cam_param;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int IDX_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              read_enable = 1'b0;
  logic [IDX_W-1:0]  read_index = '0;
  logic              write_enable = 1'b0;
  logic [IDX_W-1:0]  write_index = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic              inval_enable = 1'b0;
  logic [IDX_W-1:0]  inval_index = '0;
  logic              search_enable = 1'b0;
  logic [DATA_W-1:0] search_data = '0;
  logic [DATA_W-1:0] search_mask = '0;
  logic              read_valid;
  logic [DATA_W-1:0] read_value;
  logic              search_done;
  logic              search_valid;
  logic [IDX_W-1:0]  search_index;
  logic              search_multi;
  logic [IDX_W:0]    occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  cam_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .read_enable_i(read_enable), .read_index_i(read_index),
    .write_enable_i(write_enable), .write_index_i(write_index), .write_data_i(write_data),
    .inval_enable_i(inval_enable), .inval_index_i(inval_index),
    .search_enable_i(search_enable), .search_data_i(search_data), .search_mask_i(search_mask),
    .read_valid_o(read_valid), .read_value_o(read_value),
    .search_done_o(search_done), .search_valid_o(search_valid),
    .search_index_o(search_index), .search_multi_o(search_multi),
    .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    rst = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
    inval_enable = 1'b0; search_enable = 1'b0;
  endtask

  task automatic do_write(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d);
    applyStimulus();
    write_enable = 1'b1; write_index = idx; write_data = d;
    cycle();
    applyStimulus();
  endtask

  task automatic do_inval(input logic [IDX_W-1:0] idx);
    applyStimulus();
    inval_enable = 1'b1; inval_index = idx;
    cycle();
    applyStimulus();
  endtask

  task automatic test_reset();
    applyStimulus();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_tests++; if (occupancy !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_occ got %0d expected 0", occupancy); end
    n_tests++; if (search_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b expected 0", search_done); end
    read_enable = 1'b1; read_index = 5'd3;
    search_enable = 1'b1; search_data = 32'h0; search_mask = 32'hFFFFFFFF;
    cycle();
    applyStimulus();
    n_tests++; if (read_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_read_valid got %b expected 0", read_valid); end
    n_tests++; if (read_value !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_read_value got %h expected 0", read_value); end
    n_tests++; if (search_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done_early got %b expected 0", search_done); end
    cycle();
    n_tests++; if (search_done !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_search_done got %b expected 1", search_done); end
    n_tests++; if (search_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_search_valid got %b expected 0", search_valid); end
    n_tests++; if (search_index !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_search_index got %0d expected 0", search_index); end
    cycle();
    n_tests++; if (search_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done_single got %b expected 0", search_done); end
  endtask

  task automatic test_write_search();
    do_write(5'd5, 32'hDEADBEEF);
    do_write(5'd9, 32'hDEADBEEF);
    search_enable = 1'b1; search_data = 32'hDEADBEEF; search_mask = 32'hFFFFFFFF;
    read_enable = 1'b1; read_index = 5'd9;
    cycle();
    applyStimulus();
    n_tests++; if (read_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ws_read_valid got %b expected 1", read_valid); end
    n_tests++; if (read_value !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL ws_read_value got %h expected deadbeef", read_value); end
    cycle();
    n_tests++; if (search_done !== 1'b1) begin n_fail++; $display("[TB] FAIL ws_done got %b expected 1", search_done); end
    n_tests++; if (search_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ws_valid got %b expected 1", search_valid); end
    n_tests++; if (search_index !== 5'd5) begin n_fail++; $display("[TB] FAIL ws_index got %0d expected 5", search_index); end
    n_tests++; if (search_multi !== 1'b1) begin n_fail++; $display("[TB] FAIL ws_multi got %b expected 1", search_multi); end
    n_tests++; if (occupancy !== 6'd2) begin n_fail++; $display("[TB] FAIL ws_occ got %0d expected 2", occupancy); end
    do_write(5'd5, 32'hCAFEF00D);
    n_tests++; if (occupancy !== 6'd2) begin n_fail++; $display("[TB] FAIL ws_rewrite_occ got %0d expected 2", occupancy); end
  endtask

  task automatic test_masked_search();
    do_inval(5'd5);
    do_inval(5'd9);
    n_tests++; if (occupancy !== 6'd0) begin n_fail++; $display("[TB] FAIL ms_clear_occ got %0d expected 0", occupancy); end
    do_inval(5'd9);
    n_tests++; if (occupancy !== 6'd0) begin n_fail++; $display("[TB] FAIL ms_reinval_occ got %0d expected 0", occupancy); end
    do_write(5'd2, 32'h1234BEEF);
    do_write(5'd7, 32'h5678BEEF);
    search_enable = 1'b1; search_data = 32'h0000BEEF; search_mask = 32'h0000FFFF;
    cycle();
    applyStimulus();
    cycle();
    n_tests++; if (search_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ms_valid got %b expected 1", search_valid); end
    n_tests++; if (search_index !== 5'd2) begin n_fail++; $display("[TB] FAIL ms_index got %0d expected 2", search_index); end
    n_tests++; if (search_multi !== 1'b1) begin n_fail++; $display("[TB] FAIL ms_multi got %b expected 1", search_multi); end
    do_inval(5'd2);
    n_tests++; if (occupancy !== 6'd1) begin n_fail++; $display("[TB] FAIL ms_inval_occ got %0d expected 1", occupancy); end
    search_enable = 1'b1; search_data = 32'h0000BEEF; search_mask = 32'h0000FFFF;
    read_enable = 1'b1; read_index = 5'd2;
    cycle();
    applyStimulus();
    n_tests++; if (read_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ms_read_inval got %b expected 0", read_valid); end
    n_tests++; if (read_value !== 32'h0) begin n_fail++; $display("[TB] FAIL ms_read_inval_value got %h expected 0", read_value); end
    cycle();
    n_tests++; if (search_index !== 5'd7) begin n_fail++; $display("[TB] FAIL ms_index2 got %0d expected 7", search_index); end
    n_tests++; if (search_multi !== 1'b0) begin n_fail++; $display("[TB] FAIL ms_multi2 got %b expected 0", search_multi); end
  endtask

  task automatic test_back_to_back();
    write_enable = 1'b1; write_index = 5'd4; write_data = 32'hA5A5A5A5;
    search_enable = 1'b1; search_data = 32'hA5A5A5A5; search_mask = 32'hFFFFFFFF;
    cycle();
    applyStimulus();
    search_enable = 1'b1; search_data = 32'hA5A5A5A5; search_mask = 32'hFFFFFFFF;
    cycle();
    n_tests++; if (search_done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done1 got %b expected 1", search_done); end
    n_tests++; if (search_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_same_cycle_valid got %b expected 0", search_valid); end
    search_enable = 1'b1; search_data = 32'h5678BEEF; search_mask = 32'hFFFFFFFF;
    cycle();
    applyStimulus();
    n_tests++; if (search_done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done2 got %b expected 1", search_done); end
    n_tests++; if (search_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_valid2 got %b expected 1", search_valid); end
    n_tests++; if (search_index !== 5'd4) begin n_fail++; $display("[TB] FAIL b2b_index2 got %0d expected 4", search_index); end
    cycle();
    n_tests++; if (search_done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done3 got %b expected 1", search_done); end
    n_tests++; if (search_index !== 5'd7) begin n_fail++; $display("[TB] FAIL b2b_index3 got %0d expected 7", search_index); end
    n_tests++; if (search_multi !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_multi3 got %b expected 0", search_multi); end
    cycle();
    n_tests++; if (search_done !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_done_end got %b expected 0", search_done); end
    n_tests++; if (search_index !== 5'd0) begin n_fail++; $display("[TB] FAIL b2b_index_idle got %0d expected 0", search_index); end
    n_tests++; if (occupancy !== 6'd2) begin n_fail++; $display("[TB] FAIL b2b_occ got %0d expected 2", occupancy); end
  endtask

  task automatic test_write_inval_same_index();
    do_write(5'd31, 32'h11111111);
    n_tests++; if (occupancy !== 6'd3) begin n_fail++; $display("[TB] FAIL wi_occ_pre got %0d expected 3", occupancy); end
    write_enable = 1'b1; write_index = 5'd31; write_data = 32'h22222222;
    inval_enable = 1'b1; inval_index = 5'd31;
    read_enable = 1'b1; read_index = 5'd31;
    cycle();
    applyStimulus();
    n_tests++; if (read_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL wi_read_old_valid got %b expected 1", read_valid); end
    n_tests++; if (read_value !== 32'h11111111) begin n_fail++; $display("[TB] FAIL wi_read_old_value got %h expected 11111111", read_value); end
    n_tests++; if (occupancy !== 6'd3) begin n_fail++; $display("[TB] FAIL wi_occ got %0d expected 3", occupancy); end
    read_enable = 1'b1; read_index = 5'd31;
    cycle();
    applyStimulus();
    n_tests++; if (read_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL wi_read_new_valid got %b expected 1", read_valid); end
    n_tests++; if (read_value !== 32'h22222222) begin n_fail++; $display("[TB] FAIL wi_read_new_value got %h expected 22222222", read_value); end
    write_enable = 1'b1; write_index = 5'd0; write_data = 32'h00000000;
    inval_enable = 1'b1; inval_index = 5'd4;
    cycle();
    applyStimulus();
    n_tests++; if (occupancy !== 6'd3) begin n_fail++; $display("[TB] FAIL wi_net_occ got %0d expected 3", occupancy); end
    search_enable = 1'b1; search_data = 32'hFFFFFFFF; search_mask = 32'h0;
    cycle();
    applyStimulus();
    cycle();
    n_tests++; if (search_index !== 5'd0) begin n_fail++; $display("[TB] FAIL wi_mask0_index got %0d expected 0", search_index); end
    n_tests++; if (search_multi !== 1'b1) begin n_fail++; $display("[TB] FAIL wi_mask0_multi got %b expected 1", search_multi); end
  endtask

  task automatic test_reset_mid_search();
    search_enable = 1'b1; search_data = 32'h22222222; search_mask = 32'hFFFFFFFF;
    read_enable = 1'b1; read_index = 5'd31;
    cycle();
    applyStimulus();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_tests++; if (search_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_done got %b expected 0", search_done); end
    n_tests++; if (search_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_valid got %b expected 0", search_valid); end
    n_tests++; if (read_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_read_valid got %b expected 0", read_valid); end
    n_tests++; if (read_value !== 32'h0) begin n_fail++; $display("[TB] FAIL rm_read_value got %h expected 0", read_value); end
    n_tests++; if (occupancy !== 6'd0) begin n_fail++; $display("[TB] FAIL rm_occ got %0d expected 0", occupancy); end
    cycle();
    n_tests++; if (search_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_done_late got %b expected 0", search_done); end
    n_tests++; if (search_index !== 5'd0) begin n_fail++; $display("[TB] FAIL rm_index got %0d expected 0", search_index); end
  endtask

  initial begin
    applyStimulus();
    cycle();
    test_reset();
    test_write_search();
    test_masked_search();
    test_back_to_back();
    test_write_inval_same_index();
    test_reset_mid_search();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
